// File: rtl/scan_decoder_if.sv
// Bundles the control inputs and row-select outputs of scan_decoder.
// master drives the controls; slave is the decoder.
interface scan_decoder_if #(
  parameter int N = 3
);
  logic            ena;
  logic            mode;
  logic [N-1:0]    addr_in;
  logic [2**N-1:0] out;
  logic [N-1:0]    row;
  logic            frame_done;

  modport master (
    output ena, mode, addr_in,
    input  out, row, frame_done
  );

  modport slave (
    input  ena, mode, addr_in,
    output out, row, frame_done
  );
endinterface

// File: rtl/scan_decoder.sv
// Row decoder with direct one-hot decode or timed auto-scan (dwell + blank per row).
// Define SCAN_DECODER_ACTIVE_LOW_OUT_EN to make out active-low.
module scan_decoder #(
  parameter int N     = 3,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input logic          clk,
  input logic          rst,
  scan_decoder_if.slave bus
);
  localparam int W    = 2**N;
  localparam int MAXC = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                        : ((BLANK > 2) ? BLANK : 2);
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [W-1:0]  ONE        = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [N-1:0]  row_reg, row_next;
  logic [W-1:0]  sel_reg, sel_next;
  logic          fd_reg, fd_next;
  logic [N-1:0]  row_inc;
  logic          wrap;

  assign row_inc = row_reg + 1'b1;
  assign wrap    = &row_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      row_reg   <= '0;
      sel_reg   <= '0;
      fd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      sel_reg   <= sel_next;
      fd_reg    <= fd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = row_reg;
    sel_next   = sel_reg;
    fd_next    = 1'b0;
    if (!bus.ena) begin
      state_next = IDLE;
      cnt_next   = '0;
      row_next   = '0;
      sel_next   = '0;
    end else if (!bus.mode) begin
      // Direct decode always parks the FSM in IDLE, so re-entering scan restarts at row 0.
      state_next = IDLE;
      cnt_next   = '0;
      row_next   = bus.addr_in;
      sel_next   = ONE << bus.addr_in;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = ACTIVE;
          cnt_next   = '0;
          row_next   = '0;
          sel_next   = ONE;
        end
        ACTIVE: begin
          if (cnt_reg == DWELL_LAST) begin
            cnt_next = '0;
            if (BLANK > 0) begin
              state_next = GAP;
              sel_next   = '0;
            end else begin
              row_next = row_inc;
              sel_next = ONE << row_inc;
              fd_next  = wrap;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = ACTIVE;
            cnt_next   = '0;
            row_next   = row_inc;
            sel_next   = ONE << row_inc;
            fd_next    = wrap;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          row_next   = '0;
          sel_next   = '0;
        end
      endcase
    end
  end

`ifdef SCAN_DECODER_ACTIVE_LOW_OUT_EN
  assign bus.out = ~sel_reg;
`else
  assign bus.out = sel_reg;
`endif
  assign bus.row        = row_reg;
  assign bus.frame_done = fd_reg;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: direct sweep, scan timing, abort, async reset,
// plus a DWELL=1/BLANK=0 instance for back-to-back row stepping.
module tb_scan_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef SCAN_DECODER_ACTIVE_LOW_OUT_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  always #5 clk = ~clk;

  scan_decoder_if #(.N(3)) bus_a ();
  scan_decoder_if #(.N(3)) bus_f ();

  scan_decoder #(.N(3), .DWELL(2), .BLANK(1)) dut (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  scan_decoder #(.N(3), .DWELL(1), .BLANK(0)) dut_fast (
    .clk(clk), .rst(rst), .bus(bus_f.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] o, input logic [2:0] r, input logic f);
    check({tag, ".out"}, bus_a.out, o ^ INV);
    check({tag, ".row"}, bus_a.row, r);
    check({tag, ".fd"}, bus_a.frame_done, f);
  endtask

  initial begin
    int k;
    bus_a.ena = 1'b0; bus_a.mode = 1'b0; bus_a.addr_in = '0;
    bus_f.ena = 1'b0; bus_f.mode = 1'b0; bus_f.addr_in = '0;

    // Reset state
    #2;
    check_a("reset", 8'h00, 3'd0, 1'b0);
    check("reset_fast.out", bus_f.out, 8'h00 ^ INV);
    tick();
    tick();
    check_a("reset_held", 8'h00, 3'd0, 1'b0);
    rst = 1'b1;

    // Direct sweep
    bus_a.ena = 1'b1; bus_a.mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_a.addr_in = 3'(i);
      tick();
      check_a($sformatf("direct%0d", i), 8'(1 << i), 3'(i), 1'b0);
    end
    bus_a.ena = 1'b0; bus_a.addr_in = 3'd5;
    tick();
    check_a("direct_off", 8'h00, 3'd0, 1'b0);

    // Scan timing: 01,01,00,02,02,00,...,80,80,00,01(fd),01,00
    bus_a.ena = 1'b1; bus_a.mode = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick();
      check_a($sformatf("scan_c%0d", c), ((c % 3) == 2) ? 8'h00 : 8'(1 << (c / 3)),
              3'(c / 3), 1'b0);
    end
    tick(); check_a("scan_wrap", 8'h01, 3'd0, 1'b1);
    tick(); check_a("scan_wrap+1", 8'h01, 3'd0, 1'b0);
    tick(); check_a("scan_wrap+2", 8'h00, 3'd0, 1'b0);

    // Mid-scan abort at row 5
    k = 0;
    while (bus_a.row !== 3'd5 && k < 40) begin tick(); k++; end
    check("abort_wait_row5", bus_a.row, 3'd5);
    bus_a.mode = 1'b0; bus_a.addr_in = 3'd2;
    tick(); check_a("abort", 8'h04, 3'd2, 1'b0);
    bus_a.mode = 1'b1;
    tick(); check_a("restart", 8'h01, 3'd0, 1'b0);

    // ena=0 mid-scan
    tick(); check_a("restart+1", 8'h01, 3'd0, 1'b0);
    bus_a.ena = 1'b0;
    tick(); check_a("ena_off", 8'h00, 3'd0, 1'b0);
    bus_a.ena = 1'b1;
    tick(); check_a("ena_on", 8'h01, 3'd0, 1'b0);

    // Async reset while row 3 is lit
    k = 0;
    while (bus_a.out !== (8'h08 ^ INV) && k < 40) begin tick(); k++; end
    check("areset_wait_08", bus_a.out, 8'h08 ^ INV);
    #2 rst = 1'b0;
    #1 check_a("areset_now", 8'h00, 3'd0, 1'b0);
    tick();
    check_a("areset_held", 8'h00, 3'd0, 1'b0);
    #2 rst = 1'b1;
    tick(); check_a("areset_release", 8'h01, 3'd0, 1'b0);
    tick(); check_a("areset_release+1", 8'h01, 3'd0, 1'b0);
    tick(); check_a("areset_release+2", 8'h00, 3'd0, 1'b0);

    // DWELL=1, BLANK=0: one row per cycle, frame_done once per 8 cycles
    bus_a.ena = 1'b0;
    bus_f.ena = 1'b1; bus_f.mode = 1'b1;
    for (int c = 0; c < 17; c++) begin
      tick();
      check($sformatf("fast_c%0d.out", c), bus_f.out, 8'(1 << (c % 8)) ^ INV);
      check($sformatf("fast_c%0d.fd", c), bus_f.frame_done, (c == 8 || c == 16) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
